uart_tx_framed: RTL and testbench

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

---
 rtl/uart_tx_framed.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_framed.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framed.sv
// uart_tx_framed: FIFO-fed UART transmitter with configurable data width,
// parity and stop bits. Each frame is fetched with a single rd_en pulse,
// captured on the cycle the FIFO presents its word, then serialised LSB
// first on a registered, glitch-free TXD line.
module uart_tx_framed #(
  parameter int CLK_DIV   = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 empty,
  input  logic [DATA_BITS-1:0] data,
  output logic                 rd_en,
  output logic                 TXD,
  output logic                 busy
);

  // Reject configurations the datapath below cannot represent.
  generate
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_tx_framed: DATA_BITS must be in 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_framed: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_framed: STOP_BITS must be 1 or 2");
    end
    if (CLK_DIV < 4) begin : g_bad_clk_div
      $error("uart_tx_framed: CLK_DIV must be at least 4");
    end
  endgenerate

  localparam int              CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]      LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] PAR   = 3'd5;
  localparam logic [2:0] STOP  = 3'd6;

  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 bit_done;
  logic                 in_fetch;

  // Parity of a captured word: XOR of its bits for even, inverted for odd.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    logic p;
    p = ^w;
    if (PARITY == 1) begin
      p = ~p;
    end
    return p;
  endfunction

  assign in_fetch = (state == IDLE) || (state == REQ) || (state == LOAD);
  assign bit_done = (cnt == CNT_LAST);
  assign rd_en    = (state == REQ);
  assign busy     = (state != IDLE);

  // Bit-period timer: free-runs 0..CLK_DIV-1 while a frame is on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (in_fetch || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Parity is taken from the word on the same edge that captures it.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      par_bit <= parity_of(data);
    end
  end

  // Frame sequencer: fetch, capture, then start/data/parity/stop bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      TXD      <= 1'b1;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          TXD <= 1'b1;
          if (!empty) begin
            state <= REQ;
          end
        end
        REQ: begin
          state <= LOAD;
        end
        LOAD: begin
          shreg    <= data;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          TXD      <= 1'b0;
          state    <= START;
        end
        START: begin
          if (bit_done) begin
            TXD   <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_DATA) begin
              if (PARITY != 0) begin
                TXD   <= par_bit;
                state <= PAR;
              end else begin
                TXD   <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              TXD     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        PAR: begin
          if (bit_done) begin
            TXD   <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (stop_idx == LAST_STOP) begin
              state <= empty ? IDLE : REQ;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          TXD   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: three instances (8N1, 7E2, 8O1) at CLK_DIV=4,
// each fed by a small registered FIFO model, checked sample by sample.
module tb_uart_tx_framed;

  localparam int CD = 4;

  typedef struct {
    int         inst;
    logic [7:0] word;
    int         nbits;
    logic [10:0] bits;
    int         gap;
    bit         idle_after;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       empty [3];
  logic       rd_en [3];
  logic       txd   [3];
  logic       busy  [3];
  logic       noise [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] fifo_dout [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] dport [3];
  logic [7:0] mem [3][16];
  int         wcnt [3] = '{0, 0, 0};
  int         rptr [3] = '{0, 0, 0};
  int         checks   = 0;
  int         failures = 0;
  vec_t       tbl [6];

  always #5 clk = ~clk;

  uart_tx_framed #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .empty(empty[0]), .data(dport[0]),
    .rd_en(rd_en[0]), .TXD(txd[0]), .busy(busy[0]));

  uart_tx_framed #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .clk(clk), .rst_n(rst_n), .empty(empty[1]), .data(dport[1][6:0]),
    .rd_en(rd_en[1]), .TXD(txd[1]), .busy(busy[1]));

  uart_tx_framed #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .empty(empty[2]), .data(dport[2]),
    .rd_en(rd_en[2]), .TXD(txd[2]), .busy(busy[2]));

  // Source FIFO model: word appears on the cycle after the read strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_en[i]) begin
        fifo_dout[i] <= mem[i][rptr[i][3:0]];
        rptr[i]      <= rptr[i] + 1;
      end
    end
  end

  // Empty flag, plus optional corruption of the read data outside LOAD.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      empty[i] = (rptr[i] >= wcnt[i]);
      dport[i] = noise[i] ? ~fifo_dout[i] : fifo_dout[i];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int inst, input logic [7:0] w);
    mem[inst][wcnt[inst][3:0]] = w;
    wcnt[inst] = wcnt[inst] + 1;
  endtask

  // Wait for a start bit, then compare every cycle of the frame.
  task automatic check_frame(input int inst, input logic [10:0] bits, input int nbits,
                             input int gap, input int id, input int abort_k);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (txd[inst] == 1'b0) begin
        found = 1'b1;
        break;
      end
      n++;
    end
    chk($sformatf("f%0d_start_seen", id), int'(found), 1);
    if (!found) return;
    if (gap >= 0) chk($sformatf("f%0d_idle_gap", id), n, gap);
    for (int k = 0; k < nbits * CD; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("f%0d_txd_k%0d", id, k), int'(txd[inst]), int'(bits[k / CD]));
      if (k % CD == 0) chk($sformatf("f%0d_busy_k%0d", id, k), int'(busy[inst]), 1);
      if (k == abort_k) begin
        noise[inst] = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk($sformatf("f%0d_abort_txd", id), int'(txd[inst]), 1);
        chk($sformatf("f%0d_abort_busy", id), int'(busy[inst]), 0);
        chk($sformatf("f%0d_abort_rd_en", id), int'(rd_en[inst]), 0);
        return;
      end
      if (k == 6) noise[inst] = 1'b1;
      if (k == nbits * CD - 2) noise[inst] = 1'b0;
    end
  endtask

  task automatic idle_check(input int inst, input int id);
    @(negedge clk);
    chk($sformatf("f%0d_idle_busy", id), int'(busy[inst]), 0);
    chk($sformatf("f%0d_idle_txd", id), int'(txd[inst]), 1);
    chk($sformatf("f%0d_words_read", id), rptr[inst], wcnt[inst]);
  endtask

  task automatic release_reset(input int inst, input int id);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk($sformatf("r%0d_first_rd_en", id), int'(rd_en[inst]), 1);
    @(negedge clk);
    chk($sformatf("r%0d_rd_en_single", id), int'(rd_en[inst]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    //            inst  word   nbits bits     gap idle
    tbl[0] = '{1, 8'h41, 11, 11'h682, -1, 1'b1};  // 7E2 'A', parity 0
    tbl[1] = '{2, 8'h07, 11, 11'h40E, -1, 1'b1};  // 8O1, parity 0
    tbl[2] = '{2, 8'h0F, 11, 11'h61E, -1, 1'b1};  // 8O1, parity 1
    tbl[3] = '{0, 8'hA3, 10, 11'h346, -1, 1'b0};  // 8N1 back-to-back x3
    tbl[4] = '{0, 8'h00, 10, 11'h200,  2, 1'b0};
    tbl[5] = '{0, 8'hFF, 10, 11'h3FE,  2, 1'b1};

    // Reset held with a word waiting: line idle, no fetch.
    rst_n = 1'b0;
    push(0, 8'h55);
    repeat (5) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rst_txd_i%0d", i), int'(txd[i]), 1);
        chk($sformatf("rst_rd_en_i%0d", i), int'(rd_en[i]), 0);
        chk($sformatf("rst_busy_i%0d", i), int'(busy[i]), 0);
      end
    end

    // First frame straight out of reset: 8N1 0x55.
    release_reset(0, 0);
    check_frame(0, 11'h2AA, 10, 0, 100, -1);
    idle_check(0, 100);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].gap < 0) begin
        push(tbl[i].inst, tbl[i].word);
        for (int j = i + 1; j < 6 && tbl[j].gap == 2; j++) push(tbl[j].inst, tbl[j].word);
      end
      check_frame(tbl[i].inst, tbl[i].bits, tbl[i].nbits, tbl[i].gap, i, -1);
      if (tbl[i].idle_after) idle_check(tbl[i].inst, i);
    end

    // Abort 0x5A during its third data bit, then send 0x3C cleanly.
    push(0, 8'h5A);
    check_frame(0, 11'h2B4, 10, -1, 200, 13);
    push(0, 8'h3C);
    r0 = rptr[0];
    repeat (3) begin
      @(negedge clk);
      chk("hold_rd_en", int'(rd_en[0]), 0);
      chk("hold_txd", int'(txd[0]), 1);
      chk("hold_busy", int'(busy[0]), 0);
    end
    chk("hold_no_read", rptr[0], r0);
    release_reset(0, 1);
    check_frame(0, 11'h278, 10, 0, 201, -1);
    idle_check(0, 201);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
